// File: rtl/rca_pkg.sv
// -----------------------------------------------------------------------------
// rca_pkg
//
// Shared types and helpers for the multi-word ripple-carry add/subtract
// sequencer.
//
// Contents:
//   state_t : sequencer FSM states (2-bit encoding)
//               IDLE - waiting for an operand pair, in_ready high
//               RUN  - one DATA_WIDTH word pushed through the adder per cycle
//               DONE - result held on the output until the consumer takes it
//   idx_w() : width of the word index register for a given word count.
//             Always at least 1 bit so that NUM_WORDS=1 still has a legal
//             (constant zero) index register.
// -----------------------------------------------------------------------------
package rca_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int idx_w(input int num_words);
        int w;
        w = $clog2(num_words);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rca_multiword_seq_rca.sv
// -----------------------------------------------------------------------------
// RCA_parame
//
// Purely combinational DATA_WIDTH-bit ripple-carry adder. This is the single
// narrow slice that the sequencer reuses once per word of a wide operation.
//
// Parameters:
//   DATA_WIDTH : bits per slice
//
// Ports:
//   a   in  DATA_WIDTH  addend word
//   b   in  DATA_WIDTH  addend word (already inverted by the caller for subtract)
//   ci  in  1           carry into bit 0
//   s   out DATA_WIDTH  sum word
//   co  out 1           carry out of the top bit
// -----------------------------------------------------------------------------
module RCA_parame #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  ci,
    output logic [DATA_WIDTH-1:0] s,
    output logic                  co
);

    // c[i] is the carry into bit i; c[DATA_WIDTH] leaves the slice.
    logic [DATA_WIDTH:0] c;

    assign c[0] = ci;

    genvar i;
    generate
        for (i = 0; i < DATA_WIDTH; i++) begin : g_bit
            logic p;
            assign p      = a[i] ^ b[i];
            assign s[i]   = p ^ c[i];
            assign c[i+1] = (a[i] & b[i]) | (p & c[i]);
        end
    endgenerate

    assign co = c[DATA_WIDTH];

endmodule

// File: rtl/rca_multiword_seq.sv
// -----------------------------------------------------------------------------
// rca_multiword_seq
//
// Multi-precision add/subtract sequencer. A wide operand pair
// (NUM_WORDS x DATA_WIDTH bits) is accepted in one handshake, then pushed
// through a single DATA_WIDTH ripple-carry slice one word per cycle, least
// significant word first, with the carry registered between words. The wide
// result is presented on a valid/ready output.
//
// Parameters:
//   DATA_WIDTH  : width of the shared adder slice
//   NUM_WORDS   : words per operand (>= 1)
//   TOTAL_WIDTH : DATA_WIDTH*NUM_WORDS (derived, not overridable)
//
// Ports:
//   clk        in   1            rising-edge clock
//   reset      in   1            synchronous, active-high
//   in_valid   in   1            operand request
//   in_ready   out  1            idle, operand pair can be accepted
//   in_a       in   TOTAL_WIDTH  operand A
//   in_b       in   TOTAL_WIDTH  operand B
//   in_ci      in   1            carry-in for add (ignored for subtract)
//   in_sub     in   1            1: compute A-B
//   out_valid  out  1            result available
//   out_ready  in   1            consumer takes the result
//   out_sum    out  TOTAL_WIDTH  result modulo 2^TOTAL_WIDTH
//   out_co     out  1            final carry-out (subtract: 1 = no borrow)
//   out_ovf    out  1            two's-complement overflow of the wide op
//   busy       out  1            FSM is not idle
//   state_dbg  out  2            raw FSM state for observation
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A source holds its valid (and data) steady until it sees ready;
// ready never depends combinationally on valid. in_ready is only high in
// IDLE, so one operation is in flight at a time.
// -----------------------------------------------------------------------------
module rca_multiword_seq #(
    parameter  int DATA_WIDTH  = 32,
    parameter  int NUM_WORDS   = 4,
    localparam int TOTAL_WIDTH = DATA_WIDTH * NUM_WORDS
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [TOTAL_WIDTH-1:0] in_a,
    input  logic [TOTAL_WIDTH-1:0] in_b,
    input  logic                   in_ci,
    input  logic                   in_sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [TOTAL_WIDTH-1:0] out_sum,
    output logic                   out_co,
    output logic                   out_ovf,
    output logic                   busy,
    output logic [1:0]             state_dbg
);

    import rca_pkg::*;

    localparam int IDX_W = idx_w(NUM_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    // FSM and datapath state
    state_t                 state;
    logic [IDX_W-1:0]       idx;
    logic                   carry;
    logic [TOTAL_WIDTH-1:0] a_sh;     // operand A, shifted right one word per RUN cycle
    logic [TOTAL_WIDTH-1:0] b_sh;     // effective operand B (inverted for subtract), shifted likewise
    logic [TOTAL_WIDTH-1:0] sum_reg;
    logic                   co_reg;
    logic                   ovf_reg;
    logic                   valid_reg;
    logic                   ready_reg;
    logic                   busy_reg;

    // Adder slice signals
    logic [DATA_WIDTH-1:0]  rca_s;
    logic                   rca_co;
    logic                   last_word;
    logic                   word_ovf;

    // Operands are kept in right-shift registers, so the word being added is
    // always the bottom word: no wide index mux is needed.
    RCA_parame #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rca (
        .a  (a_sh[DATA_WIDTH-1:0]),
        .b  (b_sh[DATA_WIDTH-1:0]),
        .ci (carry),
        .s  (rca_s),
        .co (rca_co)
    );

    assign last_word = (idx == LAST_IDX);

    // On the last word the bottom of the shift registers holds the most
    // significant word, so its top bit is the sign bit of the wide operand.
    assign word_ovf = (a_sh[DATA_WIDTH-1] == b_sh[DATA_WIDTH-1]) &&
                      (rca_s[DATA_WIDTH-1] != a_sh[DATA_WIDTH-1]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            sum_reg   <= '0;
            co_reg    <= 1'b0;
            ovf_reg   <= 1'b0;
            valid_reg <= 1'b0;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // ready_reg is high throughout IDLE, so in_valid alone
                    // completes the handshake here.
                    if (in_valid) begin
                        a_sh      <= in_a;
                        b_sh      <= in_sub ? ~in_b : in_b;
                        // Subtract is A + ~B + 1; the caller's carry-in is dropped.
                        carry     <= in_sub | in_ci;
                        idx       <= '0;
                        state     <= RUN;
                        ready_reg <= 1'b0;
                        busy_reg  <= 1'b1;
                    end
                end

                RUN: begin
                    // New sum word enters at the top; after NUM_WORDS shifts
                    // the first (least significant) word has reached bit 0.
                    sum_reg <= TOTAL_WIDTH'({rca_s, sum_reg} >> DATA_WIDTH);
                    carry   <= rca_co;
                    a_sh    <= a_sh >> DATA_WIDTH;
                    b_sh    <= b_sh >> DATA_WIDTH;
                    if (last_word) begin
                        idx       <= '0;
                        co_reg    <= rca_co;
                        ovf_reg   <= word_ovf;
                        valid_reg <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        valid_reg <= 1'b0;
                        ready_reg <= 1'b1;
                        busy_reg  <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    valid_reg <= 1'b0;
                    ready_reg <= 1'b1;
                    busy_reg  <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = ready_reg;
    assign busy      = busy_reg;
    assign out_valid = valid_reg;
    assign out_sum   = sum_reg;
    assign out_co    = co_reg;
    assign out_ovf   = ovf_reg;
    assign state_dbg = state;

endmodule
